sort_data_mem: RTL

- Parametrised successor to the sorter's word-addressed data memory.
- Keeps the write/read command interface of the current data memory.
- Adds an in-memory compare-and-swap (CSWAP) engine that performs one bubble-sort step per command.
- Adds a sequenced clear in place of a combinational reset wipe.
- Sits between the sort controller and storage; the controller issues one command at a time and polls busy/done.

---
 rtl/sort_data_mem_if.sv | 40 ++++
 rtl/sort_data_mem.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sort_data_mem_if.sv
// Command/response bundle between the sort controller and sort_data_mem.
// Optional swap_count member is present only when SWAP_COUNT_EN is defined.
`timescale 1ns/1ps
interface sort_data_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              cmd_valid;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] address1;
  logic [ADDR_W-1:0] address2;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;
  logic              swapped;
`ifdef SWAP_COUNT_EN
  logic [15:0]       swap_count;

  modport master (
    output cmd_valid, mode, address1, address2, data_in,
    input  data_out, busy, done, swapped, swap_count
  );

  modport slave (
    input  cmd_valid, mode, address1, address2, data_in,
    output data_out, busy, done, swapped, swap_count
  );
`else
  modport master (
    output cmd_valid, mode, address1, address2, data_in,
    input  data_out, busy, done, swapped
  );

  modport slave (
    input  cmd_valid, mode, address1, address2, data_in,
    output data_out, busy, done, swapped
  );
`endif
endinterface

// File: rtl/sort_data_mem.sv
// Word-addressed sorter data memory with in-place compare-and-swap and sequenced clear.
// Define SWAP_COUNT_EN to add the saturating swap_count output.
`timescale 1ns/1ps
module sort_data_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input logic            clk,
  input logic            rst,
  sort_data_mem_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_CS_RD  = 3'd2;
  localparam logic [2:0] S_CS_CMP = 3'd3;
  localparam logic [2:0] S_CS_WR2 = 3'd4;

  localparam logic [1:0] M_READ  = 2'b00;
  localparam logic [1:0] M_WRITE = 2'b01;
  localparam logic [1:0] M_CSWAP = 2'b10;
  localparam logic [1:0] M_CLEAR = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addrA_q, addrA_d;
  logic [ADDR_W-1:0] addrB_q, addrB_d;
  logic [DATA_W-1:0] opA_q, opA_d;
  logic [DATA_W-1:0] opB_q, opB_d;
  logic [DATA_W-1:0] dataOut_q, dataOut_d;
  logic              done_q, done_d;
  logic              swapped_q, swapped_d;

  logic              memWe;
  logic [ADDR_W-1:0] memWAddr;
  logic [DATA_W-1:0] memWData;
  logic [ADDR_W-1:0] rdAddrB;
  logic [DATA_W-1:0] rdDataA;
  logic [DATA_W-1:0] rdDataB;

  function automatic logic inRange(input logic [ADDR_W-1:0] a);
    return {{(32-ADDR_W){1'b0}}, a} < 32'(DEPTH);
  endfunction

  // Port B serves READ commands while idle and the CSWAP upper operand otherwise.
  assign rdAddrB = (state_q == S_IDLE) ? bus.address2 : addrB_q;
  assign rdDataA = inRange(addrA_q) ? mem[addrA_q] : '0;
  assign rdDataB = inRange(rdAddrB) ? mem[rdAddrB] : '0;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    addrA_d   = addrA_q;
    addrB_d   = addrB_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    dataOut_d = dataOut_q;
    done_d    = 1'b0;
    swapped_d = swapped_q;
    memWe     = 1'b0;
    memWAddr  = '0;
    memWData  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.mode)
            M_READ: dataOut_d = rdDataB;
            M_WRITE: begin
              if (inRange(bus.address1)) begin
                memWe    = 1'b1;
                memWAddr = bus.address1;
                memWData = bus.data_in;
              end
            end
            M_CSWAP: begin
              addrA_d = bus.address1;
              addrB_d = bus.address2;
              state_d = S_CS_RD;
            end
            default: begin
              ptr_d   = '0;
              state_d = S_CLR;
            end
          endcase
        end
      end
      S_CLR: begin
        memWe    = 1'b1;
        memWAddr = ptr_q;
        memWData = '0;
        if (ptr_q == LAST_ADDR) begin
          ptr_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_CS_RD: begin
        opA_d   = rdDataA;
        opB_d   = rdDataB;
        state_d = S_CS_CMP;
      end
      // The two halves of a swap land on consecutive cycles to keep one write port.
      S_CS_CMP: begin
        if (opA_q > opB_q) begin
          if (inRange(addrA_q)) begin
            memWe    = 1'b1;
            memWAddr = addrA_q;
            memWData = opB_q;
          end
          state_d = S_CS_WR2;
        end else begin
          swapped_d = 1'b0;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_CS_WR2: begin
        if (inRange(addrB_q)) begin
          memWe    = 1'b1;
          memWAddr = addrB_q;
          memWData = opA_q;
        end
        swapped_d = 1'b1;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLR;
      ptr_q     <= '0;
      addrA_q   <= '0;
      addrB_q   <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      dataOut_q <= '0;
      done_q    <= 1'b0;
      swapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      addrA_q   <= addrA_d;
      addrB_q   <= addrB_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      dataOut_q <= dataOut_d;
      done_q    <= done_d;
      swapped_q <= swapped_d;
    end
  end

  // Storage itself is not reset; the CLR sequence zeroes it after rst.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memWAddr] <= memWData;
    end
  end

  assign bus.data_out = dataOut_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.swapped  = swapped_q;

`ifdef SWAP_COUNT_EN
  logic [15:0] swapCount_q, swapCount_d;

  always_comb begin
    swapCount_d = swapCount_q;
    if (state_q == S_IDLE && bus.cmd_valid && bus.mode == M_CLEAR) begin
      swapCount_d = '0;
    end else if (state_q == S_CS_WR2 && swapCount_q != 16'hFFFF) begin
      swapCount_d = swapCount_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swapCount_q <= '0;
    end else begin
      swapCount_q <= swapCount_d;
    end
  end

  assign bus.swap_count = swapCount_q;
`endif

endmodule
